// File: rtl/udp_message_receiver.sv
// MII (4-bit) UDP/IPv4 receiver: keeps frames addressed to this board, streams the UDP payload
// into a byte FIFO and gives a per-frame good/bad verdict from FCS, length and rx_er.
module udp_message_receiver #(
  parameter int unsigned MAX_PAYLOAD  = 1472,
  parameter bit          ACCEPT_BCAST = 1'b1
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [47:0] BOARD_MAC,
  input  logic [31:0] BOARD_IP,
  input  logic [15:0] BOARD_PORT,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [3:0]  rxd,
  output logic [7:0]  dataout,
  output logic        wrreq,
  output logic        sof,
  output logic        eof,
  output logic        frame_ok,
  output logic        frame_bad,
  output logic [47:0] PC_MAC,
  output logic [31:0] PC_IP,
  output logic [15:0] PC_PORT,
  output logic [15:0] payload_len,
  output logic [15:0] good_cnt,
  output logic [15:0] drop_cnt
);

  localparam logic [31:0] CrcPoly    = 32'hEDB88320;
  localparam logic [31:0] CrcResidue = 32'hDEBB20E3;
  localparam logic [15:0] MaxUdpLen  = 16'(MAX_PAYLOAD + 8);
  localparam logic [10:0] ByteCntMax = 11'h7FF;

  typedef enum logic [2:0] {
    StWaitIdle, StIdle, StPreamble, StHeader, StPayload, StTrail, StDrop
  } state_e;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ ((c[0] ^ data[i]) ? CrcPoly : 32'h0);
    end
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic        phase_q, phase_d;
  logic [3:0]  lo_q, lo_d;
  logic [31:0] crc_q, crc_d;
  logic        err_q, err_d;
  logic        uc_ok_q, uc_ok_d, bc_ok_q, bc_ok_d;
  logic [15:0] len_q, len_d;
  logic [47:0] mac_sh_q, mac_sh_d;
  logic [31:0] ip_sh_q, ip_sh_d;
  logic [15:0] port_sh_q, port_sh_d;
  logic [7:0]  dataout_q, dataout_d;
  logic        wrreq_q, wrreq_d, sof_q, sof_d, eof_q, eof_d;
  logic        frame_ok_q, frame_ok_d, frame_bad_q, frame_bad_d;
  logic [47:0] pc_mac_q, pc_mac_d;
  logic [31:0] pc_ip_q, pc_ip_d;
  logic [15:0] pc_port_q, pc_port_d;
  logic [15:0] payload_len_q, payload_len_d;
  logic [15:0] good_cnt_q, good_cnt_d, drop_cnt_q, drop_cnt_d;

  logic [7:0]  cur_byte, mac_byte, ip_byte, port_byte;
  logic [15:0] byte_cnt16;
  logic        hdr_fail, frame_good;

  // Header bytes arrive MSB-first; pick the matching own-address byte by position.
  assign cur_byte   = {rxd, lo_q};
  assign mac_byte   = 8'(BOARD_MAC >> {3'd5 - byte_cnt_q[2:0], 3'b000});
  assign ip_byte    = 8'(BOARD_IP >> {2'd1 - byte_cnt_q[1:0], 3'b000});
  assign port_byte  = byte_cnt_q[0] ? BOARD_PORT[7:0] : BOARD_PORT[15:8];
  assign byte_cnt16 = {5'd0, byte_cnt_q};
  assign frame_good = (crc_q == CrcResidue) && !phase_q && !err_q && (byte_cnt_q >= 11'd64) &&
                      (byte_cnt16 >= payload_len_q + 16'd46);

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    phase_d       = phase_q;
    lo_d          = lo_q;
    crc_d         = crc_q;
    err_d         = err_q;
    uc_ok_d       = uc_ok_q;
    bc_ok_d       = bc_ok_q;
    len_d         = len_q;
    mac_sh_d      = mac_sh_q;
    ip_sh_d       = ip_sh_q;
    port_sh_d     = port_sh_q;
    dataout_d     = dataout_q;
    wrreq_d       = 1'b0;
    sof_d         = 1'b0;
    eof_d         = 1'b0;
    frame_ok_d    = 1'b0;
    frame_bad_d   = 1'b0;
    pc_mac_d      = pc_mac_q;
    pc_ip_d       = pc_ip_q;
    pc_port_d     = pc_port_q;
    payload_len_d = payload_len_q;
    good_cnt_d    = good_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    hdr_fail      = 1'b0;

    case (state_q)
      StWaitIdle: if (!rx_dv) state_d = StIdle;
      StIdle: begin
        if (rx_dv) begin
          state_d = (rxd == 4'h5) ? StPreamble : StDrop;
          err_d   = rx_er;
        end
      end
      StPreamble: begin
        if (!rx_dv) begin
          state_d = StIdle;
        end else begin
          err_d = err_q | rx_er;
          if (rxd == 4'hD) begin
            state_d    = StHeader;
            byte_cnt_d = '0;
            phase_d    = 1'b0;
            crc_d      = '1;
            uc_ok_d    = 1'b1;
            bc_ok_d    = ACCEPT_BCAST;
          end else if (rxd != 4'h5) begin
            state_d = StDrop;
          end
        end
      end
      StHeader, StPayload, StTrail: begin
        if (!rx_dv) begin
          state_d = StIdle;
          if (state_q == StHeader) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end else if (frame_good) begin
            frame_ok_d = 1'b1;
            good_cnt_d = good_cnt_q + 16'd1;
            pc_mac_d   = mac_sh_q;
            pc_ip_d    = ip_sh_q;
            pc_port_d  = port_sh_q;
          end else begin
            frame_bad_d = 1'b1;
            drop_cnt_d  = drop_cnt_q + 16'd1;
          end
        end else begin
          err_d   = err_q | rx_er;
          phase_d = ~phase_q;
          if (!phase_q) begin
            lo_d = rxd;
          end else begin
            crc_d = crc_byte(crc_q, cur_byte);
            if (byte_cnt_q != ByteCntMax) byte_cnt_d = byte_cnt_q + 11'd1;
            if (state_q == StHeader) begin
              case (byte_cnt_q) inside
                [11'd0:11'd5]: begin
                  uc_ok_d  = uc_ok_q && (cur_byte == mac_byte);
                  bc_ok_d  = bc_ok_q && (cur_byte == 8'hFF);
                  hdr_fail = !(uc_ok_d || bc_ok_d);
                end
                [11'd6:11'd11]:  mac_sh_d = {mac_sh_q[39:0], cur_byte};
                11'd12:          hdr_fail = (cur_byte != 8'h08);
                11'd13:          hdr_fail = (cur_byte != 8'h00);
                11'd14:          hdr_fail = (cur_byte != 8'h45);
                11'd23:          hdr_fail = (cur_byte != 8'h11);
                [11'd26:11'd29]: ip_sh_d = {ip_sh_q[23:0], cur_byte};
                [11'd30:11'd33]: hdr_fail = (cur_byte != ip_byte);
                [11'd34:11'd35]: port_sh_d = {port_sh_q[7:0], cur_byte};
                [11'd36:11'd37]: hdr_fail = (cur_byte != port_byte);
                11'd38:          len_d = {cur_byte, 8'h00};
                11'd39: begin
                  len_d    = {len_q[15:8], cur_byte};
                  hdr_fail = (len_d < 16'd8) || (len_d > MaxUdpLen);
                  if (!hdr_fail) payload_len_d = len_d - 16'd8;
                end
                11'd41:          state_d = (len_q == 16'd8) ? StTrail : StPayload;
                default: ;
              endcase
              if (hdr_fail) begin
                state_d    = StDrop;
                drop_cnt_d = drop_cnt_q + 16'd1;
              end
            end else if (state_q == StPayload) begin
              wrreq_d   = 1'b1;
              dataout_d = cur_byte;
              sof_d     = (byte_cnt_q == 11'd42);
              if (byte_cnt16 == payload_len_q + 16'd41) begin
                eof_d   = 1'b1;
                state_d = StTrail;
              end
            end
          end
        end
      end
      StDrop: if (!rx_dv) state_d = StIdle;
      default: state_d = StWaitIdle;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StWaitIdle;
      byte_cnt_q    <= '0;
      phase_q       <= 1'b0;
      lo_q          <= '0;
      crc_q         <= '1;
      err_q         <= 1'b0;
      uc_ok_q       <= 1'b0;
      bc_ok_q       <= 1'b0;
      len_q         <= '0;
      mac_sh_q      <= '0;
      ip_sh_q       <= '0;
      port_sh_q     <= '0;
      dataout_q     <= '0;
      wrreq_q       <= 1'b0;
      sof_q         <= 1'b0;
      eof_q         <= 1'b0;
      frame_ok_q    <= 1'b0;
      frame_bad_q   <= 1'b0;
      pc_mac_q      <= '0;
      pc_ip_q       <= '0;
      pc_port_q     <= '0;
      payload_len_q <= '0;
      good_cnt_q    <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      phase_q       <= phase_d;
      lo_q          <= lo_d;
      crc_q         <= crc_d;
      err_q         <= err_d;
      uc_ok_q       <= uc_ok_d;
      bc_ok_q       <= bc_ok_d;
      len_q         <= len_d;
      mac_sh_q      <= mac_sh_d;
      ip_sh_q       <= ip_sh_d;
      port_sh_q     <= port_sh_d;
      dataout_q     <= dataout_d;
      wrreq_q       <= wrreq_d;
      sof_q         <= sof_d;
      eof_q         <= eof_d;
      frame_ok_q    <= frame_ok_d;
      frame_bad_q   <= frame_bad_d;
      pc_mac_q      <= pc_mac_d;
      pc_ip_q       <= pc_ip_d;
      pc_port_q     <= pc_port_d;
      payload_len_q <= payload_len_d;
      good_cnt_q    <= good_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign dataout     = dataout_q;
  assign wrreq       = wrreq_q;
  assign sof         = sof_q;
  assign eof         = eof_q;
  assign frame_ok    = frame_ok_q;
  assign frame_bad   = frame_bad_q;
  assign PC_MAC      = pc_mac_q;
  assign PC_IP       = pc_ip_q;
  assign PC_PORT     = pc_port_q;
  assign payload_len = payload_len_q;
  assign good_cnt    = good_cnt_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_udp_message_receiver.sv
// Bench for udp_message_receiver: builds whole frames as byte queues, predicts the FIFO writes
// and verdict from the frame contents, and compares against what the DUT produces.
module tb_udp_message_receiver;

  localparam int MaxPayload  = 1472;
  localparam bit AcceptBcast = 1'b1;

  typedef logic [7:0] byte_t;
  typedef byte_t bq_t[$];

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] board_mac;
  logic [31:0] board_ip;
  logic [15:0] board_port;
  logic        rx_dv = 1'b0, rx_er = 1'b0;
  logic [3:0]  rxd = 4'h0;
  logic [7:0]  dataout;
  logic        wrreq, sof, eof, frame_ok, frame_bad;
  logic [47:0] pc_mac;
  logic [31:0] pc_ip;
  logic [15:0] pc_port, payload_len, good_cnt, drop_cnt;

  always #20 clock = ~clock;

  udp_message_receiver #(
    .MAX_PAYLOAD (MaxPayload),
    .ACCEPT_BCAST(AcceptBcast)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .BOARD_MAC  (board_mac),
    .BOARD_IP   (board_ip),
    .BOARD_PORT (board_port),
    .rx_dv      (rx_dv),
    .rx_er      (rx_er),
    .rxd        (rxd),
    .dataout    (dataout),
    .wrreq      (wrreq),
    .sof        (sof),
    .eof        (eof),
    .frame_ok   (frame_ok),
    .frame_bad  (frame_bad),
    .PC_MAC     (pc_mac),
    .PC_IP      (pc_ip),
    .PC_PORT    (pc_port),
    .payload_len(payload_len),
    .good_cnt   (good_cnt),
    .drop_cnt   (drop_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Observed and predicted FIFO writes, each entry {sof, eof, data}.
  logic [9:0]  got_wr[$], exp_wr[$];
  int          got_ok, got_bad, exp_ok, exp_bad;
  logic [15:0] exp_good = '0, exp_drop = '0, exp_plen = '0;
  logic [47:0] exp_pc_mac = '0;
  logic [31:0] exp_pc_ip = '0;
  logic [15:0] exp_pc_port = '0;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic [15:0] src_port;

  always @(negedge clock) begin
    if (wrreq) got_wr.push_back({sof, eof, dataout});
    if (frame_ok) got_ok++;
    if (frame_bad) got_bad++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] crc32(input bq_t f);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (f[i]) begin
      c = c ^ {24'd0, f[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic bq_t build_frame(input logic [47:0] dmac, input logic [15:0] etype,
                                      input logic [31:0] dip, input logic [15:0] dport,
                                      input logic [15:0] ulen, input int npay, input bit seq);
    bq_t         f;
    logic [31:0] fcs;
    logic [15:0] iplen;
    iplen = ulen + 16'd20;
    for (int i = 5; i >= 0; i--) f.push_back(dmac[8*i +: 8]);
    for (int i = 5; i >= 0; i--) f.push_back(src_mac[8*i +: 8]);
    f.push_back(etype[15:8]);  f.push_back(etype[7:0]);
    f.push_back(8'h45);        f.push_back(8'h00);
    f.push_back(iplen[15:8]);  f.push_back(iplen[7:0]);
    repeat (4) f.push_back(8'h00);
    f.push_back(8'h40);        f.push_back(8'h11);
    f.push_back(8'h00);        f.push_back(8'h00);
    for (int i = 3; i >= 0; i--) f.push_back(src_ip[8*i +: 8]);
    for (int i = 3; i >= 0; i--) f.push_back(dip[8*i +: 8]);
    f.push_back(src_port[15:8]); f.push_back(src_port[7:0]);
    f.push_back(dport[15:8]);    f.push_back(dport[7:0]);
    f.push_back(ulen[15:8]);     f.push_back(ulen[7:0]);
    f.push_back(8'h00);          f.push_back(8'h00);
    for (int i = 0; i < npay; i++) f.push_back(seq ? 8'(i + 1) : 8'($urandom));
    while (f.size() < 60) f.push_back(8'h00);
    fcs = ~crc32(f);
    for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
    return f;
  endfunction

  // Reference model: decide from the frame bytes what the receiver must do with them.
  function automatic void predict(input bq_t f, input bit had_er);
    int          n, plen;
    logic [47:0] dm;
    logic [31:0] di;
    logic [15:0] dp, et, ulen;
    bit          rej;
    n = f.size();
    exp_wr.delete();
    exp_ok  = 0;
    exp_bad = 0;
    dm   = {f[0], f[1], f[2], f[3], f[4], f[5]};
    et   = {f[12], f[13]};
    di   = {f[30], f[31], f[32], f[33]};
    dp   = {f[36], f[37]};
    ulen = {f[38], f[39]};
    rej = !(dm == board_mac || (AcceptBcast && dm == 48'hFFFF_FFFF_FFFF)) ||
          et != 16'h0800 || f[14] != 8'h45 || f[23] != 8'h11 || di != board_ip ||
          dp != board_port || int'(ulen) < 8 || int'(ulen) > MaxPayload + 8;
    if (rej) begin
      exp_drop = exp_drop + 16'd1;
      return;
    end
    plen     = int'(ulen) - 8;
    exp_plen = 16'(plen);
    for (int i = 42; i <= 41 + plen && i < n; i++) begin
      exp_wr.push_back({i == 42, i == 41 + plen, f[i]});
    end
    if (crc32(f) == 32'hDEBB20E3 && !had_er && n >= 64 && n >= 46 + plen) begin
      exp_ok      = 1;
      exp_good    = exp_good + 16'd1;
      exp_pc_mac  = {f[6], f[7], f[8], f[9], f[10], f[11]};
      exp_pc_ip   = {f[26], f[27], f[28], f[29]};
      exp_pc_port = {f[34], f[35]};
    end else begin
      exp_bad  = 1;
      exp_drop = exp_drop + 16'd1;
    end
  endfunction

  task automatic drive_nib(input logic [3:0] n, input logic er);
    @(negedge clock);
    rx_dv = 1'b1;
    rxd   = n;
    rx_er = er;
  endtask

  task automatic drive_idle(input int cycles);
    repeat (cycles) begin
      @(negedge clock);
      rx_dv = 1'b0;
      rxd   = 4'h0;
      rx_er = 1'b0;
    end
  endtask

  task automatic send_frame(input bq_t f, input int er_at);
    @(posedge clock);
    got_wr.delete();
    got_ok  = 0;
    got_bad = 0;
    repeat (15) drive_nib(4'h5, 1'b0);
    drive_nib(4'hD, 1'b0);
    foreach (f[i]) begin
      drive_nib(f[i][3:0], 2 * i == er_at);
      drive_nib(f[i][7:4], 1'b0);
    end
    drive_idle(12);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_dv = 1'b1;
    rxd   = 4'h5;
    repeat (3) @(negedge clock);
    checks++;
    if ({dataout, wrreq, sof, eof, frame_ok, frame_bad} !== 13'd0) begin
      errors++;
      $display("FAIL reset_strobes: got %h want 0", {dataout, wrreq, sof, eof, frame_ok, frame_bad});
    end
    checks++;
    if ({good_cnt, drop_cnt, payload_len} !== 48'd0) begin
      errors++;
      $display("FAIL reset_counts: got %h want 0", {good_cnt, drop_cnt, payload_len});
    end
    checks++;
    if ({pc_mac, pc_ip, pc_port} !== 96'd0) begin
      errors++;
      $display("FAIL reset_pc: got %h want 0", {pc_mac, pc_ip, pc_port});
    end
    @(posedge clock);
    #5 rst_n = 1'b1;
    repeat (6) drive_nib(4'h5, 1'b0);
    drive_idle(4);
  endtask

  task automatic test_valid_frame();
    bq_t f;
    src_port = 16'h1F90;
    f = build_frame(board_mac, 16'h0800, board_ip, board_port, 16'h0010, 8, 1'b1);
    predict(f, 1'b0);
    send_frame(f, -1);
    checks++;
    if (got_wr.size() != 8) begin
      errors++;
      $display("FAIL valid_wr_count: got %0d want 8", got_wr.size());
    end
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin
        errors++;
        $display("FAIL valid_wr[%0d]: got %h want %h", i, got_wr[i], exp_wr[i]);
      end
    end
    checks++;
    if (got_ok != 1 || got_bad != 0) begin
      errors++;
      $display("FAIL valid_verdict: got ok=%0d bad=%0d want ok=1 bad=0", got_ok, got_bad);
    end
    checks++;
    if (good_cnt !== 16'd1 || payload_len !== 16'd8) begin
      errors++;
      $display("FAIL valid_counts: got good=%0d len=%0d want 1 8", good_cnt, payload_len);
    end
    checks++;
    if ({pc_mac, pc_ip, pc_port} !== {src_mac, src_ip, 16'h1F90}) begin
      errors++;
      $display("FAIL valid_pc: got %h want %h", {pc_mac, pc_ip, pc_port},
               {src_mac, src_ip, 16'h1F90});
    end
  endtask

  task automatic test_bad_fcs();
    bq_t         f;
    logic [95:0] pc_before;
    pc_before = {exp_pc_mac, exp_pc_ip, exp_pc_port};
    src_mac   = {$urandom, $urandom};
    f = build_frame(board_mac, 16'h0800, board_ip, board_port, 16'h0010, 8, 1'b1);
    f[45] = f[45] ^ 8'h10;
    predict(f, 1'b0);
    send_frame(f, -1);
    checks++;
    if (got_wr.size() != 8) begin
      errors++;
      $display("FAIL badfcs_wr_count: got %0d want 8", got_wr.size());
    end
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin
        errors++;
        $display("FAIL badfcs_wr[%0d]: got %h want %h", i, got_wr[i], exp_wr[i]);
      end
    end
    checks++;
    if (got_ok != 0 || got_bad != 1) begin
      errors++;
      $display("FAIL badfcs_verdict: got ok=%0d bad=%0d want ok=0 bad=1", got_ok, got_bad);
    end
    checks++;
    if ({pc_mac, pc_ip, pc_port} !== pc_before || drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL badfcs_state: got pc=%h drop=%0d want pc=%h drop=1",
               {pc_mac, pc_ip, pc_port}, drop_cnt, pc_before);
    end
  endtask

  task automatic test_header_reject();
    bq_t f;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) f = build_frame(board_mac, 16'h0800, ~board_ip, board_port, 16'd20, 12, 1'b0);
      else        f = build_frame(board_mac, 16'h0806, board_ip, board_port, 16'd20, 12, 1'b0);
      predict(f, 1'b0);
      send_frame(f, -1);
      checks++;
      if (got_wr.size() != 0 || got_ok != 0 || got_bad != 0) begin
        errors++;
        $display("FAIL reject%0d_outputs: got wr=%0d ok=%0d bad=%0d want 0 0 0", k,
                 got_wr.size(), got_ok, got_bad);
      end
      checks++;
      if (drop_cnt !== exp_drop || good_cnt !== exp_good) begin
        errors++;
        $display("FAIL reject%0d_counts: got drop=%0d good=%0d want %0d %0d", k, drop_cnt,
                 good_cnt, exp_drop, exp_good);
      end
    end
  endtask

  task automatic test_truncated();
    bq_t f, t;
    f = build_frame(board_mac, 16'h0800, board_ip, board_port, 16'd28, 20, 1'b0);
    for (int i = 0; i < 45; i++) t.push_back(f[i]);
    predict(t, 1'b0);
    send_frame(t, -1);
    checks++;
    if (got_wr.size() != 3) begin
      errors++;
      $display("FAIL trunc_wr_count: got %0d want 3", got_wr.size());
    end
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin
        errors++;
        $display("FAIL trunc_wr[%0d]: got %h want %h (no eof expected)", i, got_wr[i], exp_wr[i]);
      end
    end
    checks++;
    if (got_ok != 0 || got_bad != 1 || drop_cnt !== exp_drop) begin
      errors++;
      $display("FAIL trunc_verdict: got ok=%0d bad=%0d drop=%0d want 0 1 %0d", got_ok, got_bad,
               drop_cnt, exp_drop);
    end
  endtask

  task automatic test_reset_mid_frame();
    bq_t f;
    f = build_frame(board_mac, 16'h0800, board_ip, board_port, 16'd28, 20, 1'b0);
    @(posedge clock);
    got_wr.delete();
    got_ok  = 0;
    got_bad = 0;
    repeat (15) drive_nib(4'h5, 1'b0);
    drive_nib(4'hD, 1'b0);
    for (int i = 0; i < 2 * f.size(); i++) begin
      drive_nib((i % 2 == 1) ? f[i / 2][7:4] : f[i / 2][3:0], 1'b0);
      if (i == 90) begin
        @(posedge clock);
        #5 rst_n = 1'b0;
      end
      if (i == 100) begin
        @(posedge clock);
        #5;
        checks++;
        if ({wrreq, dataout, good_cnt, drop_cnt, payload_len, pc_mac} !== '0) begin
          errors++;
          $display("FAIL midreset_clear: got wrreq=%b data=%h good=%0d drop=%0d len=%0d want 0",
                   wrreq, dataout, good_cnt, drop_cnt, payload_len);
        end
        rst_n = 1'b1;
      end
    end
    drive_idle(12);
    exp_good    = '0;
    exp_drop    = '0;
    exp_plen    = '0;
    exp_pc_mac  = '0;
    exp_pc_ip   = '0;
    exp_pc_port = '0;
    checks++;
    if (got_wr.size() != 3 || got_ok != 0 || got_bad != 0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midreset_after: got wr=%0d ok=%0d bad=%0d drop=%0d want 3 0 0 0",
               got_wr.size(), got_ok, got_bad, drop_cnt);
    end
    f = build_frame(board_mac, 16'h0800, board_ip, board_port, 16'd12, 4, 1'b0);
    predict(f, 1'b0);
    send_frame(f, -1);
    checks++;
    if (got_wr != exp_wr || got_ok != 1 || good_cnt !== 16'd1) begin
      errors++;
      $display("FAIL midreset_next: got wr=%0d ok=%0d good=%0d want %0d 1 1", got_wr.size(),
               got_ok, good_cnt, exp_wr.size());
    end
  endtask

  task automatic test_bcast_oversize();
    bq_t f;
    f = build_frame(48'hFFFF_FFFF_FFFF, 16'h0800, board_ip, board_port, 16'd14, 6, 1'b0);
    predict(f, 1'b0);
    send_frame(f, -1);
    checks++;
    if (got_wr != exp_wr || got_ok != 1 || good_cnt !== exp_good) begin
      errors++;
      $display("FAIL bcast: got wr=%0d ok=%0d good=%0d want 6 1 %0d", got_wr.size(), got_ok,
               good_cnt, exp_good);
    end
    f = build_frame(board_mac, 16'h0800, board_ip, board_port, 16'(MaxPayload + 9), 8, 1'b0);
    predict(f, 1'b0);
    send_frame(f, -1);
    checks++;
    if (got_wr.size() != 0 || got_ok + got_bad != 0 || drop_cnt !== exp_drop) begin
      errors++;
      $display("FAIL oversize: got wr=%0d pulses=%0d drop=%0d want 0 0 %0d", got_wr.size(),
               got_ok + got_bad, drop_cnt, exp_drop);
    end
    checks++;
    if (payload_len !== 16'd6) begin
      errors++;
      $display("FAIL oversize_len: got %0d want 6", payload_len);
    end
  endtask

  task automatic test_back_to_back();
    bq_t         f;
    int          kind, npay, er_at;
    logic [47:0] dmac;
    logic [15:0] dport;
    for (int k = 0; k < 16; k++) begin
      kind     = int'($urandom_range(0, 5));
      npay     = int'($urandom_range(0, 50));
      src_mac  = {$urandom, $urandom};
      src_ip   = $urandom;
      src_port = 16'($urandom);
      dmac     = (kind == 5) ? 48'hFFFF_FFFF_FFFF : board_mac;
      dport    = (kind == 3) ? ~board_port : board_port;
      er_at    = (kind == 4) ? 100 : -1;
      f = build_frame(dmac, 16'h0800, board_ip, dport, 16'(npay + 8), npay, 1'b0);
      if (kind == 2) f[$urandom_range(42, 58)] ^= 8'h80;
      predict(f, kind == 4);
      send_frame(f, er_at);
      checks++;
      if (got_wr != exp_wr) begin
        errors++;
        $display("FAIL b2b%0d_writes: got %0d entries want %0d (kind %0d)", k, got_wr.size(),
                 exp_wr.size(), kind);
      end
      checks++;
      if (got_ok != exp_ok || got_bad != exp_bad) begin
        errors++;
        $display("FAIL b2b%0d_verdict: got ok=%0d bad=%0d want %0d %0d", k, got_ok, got_bad,
                 exp_ok, exp_bad);
      end
      checks++;
      if ({good_cnt, drop_cnt, payload_len} !== {exp_good, exp_drop, exp_plen}) begin
        errors++;
        $display("FAIL b2b%0d_counts: got %h want %h", k, {good_cnt, drop_cnt, payload_len},
                 {exp_good, exp_drop, exp_plen});
      end
      checks++;
      if ({pc_mac, pc_ip, pc_port} !== {exp_pc_mac, exp_pc_ip, exp_pc_port}) begin
        errors++;
        $display("FAIL b2b%0d_pc: got %h want %h", k, {pc_mac, pc_ip, pc_port},
                 {exp_pc_mac, exp_pc_ip, exp_pc_port});
      end
    end
  endtask

  initial begin
    board_mac  = {16'h02A5, $urandom};
    board_ip   = $urandom;
    board_port = 16'h1F90;
    src_mac    = {16'h0A1B, $urandom};
    src_ip     = $urandom;
    src_port   = 16'h1F90;
    test_reset();
    test_valid_frame();
    test_bad_fcs();
    test_header_reject();
    test_truncated();
    test_reset_mid_frame();
    test_bcast_oversize();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
